diff_word_encoder: RTL and testbench
====================================

// Module: diff_word_encoder
// PURPOSE
//  Streaming differential encoder for DNA words: accepts one 2-bit digit per handshake, differentially
//  encodes it (running sum mod 4) and packs it into an N-digit word. On word completion it presents the
//  packed word plus its length to the downstream digit-removal stage (M-digit shrink) via valid/ready.
//  Sits directly upstream of that stage; its word_out/word_len feed that stage's word_in/word_in_len.
// PARAMETERS
//  N         128   digits per packed word (2 bits each); N <= 128 so length fits 7 bits
//  INIT_REF  2'd0  reference digit the differential chain starts from at each new word
// PORTS
//  clk        in   1     clock, rising edge
//  rst        in   1     reset, asynchronous, active-high
//  in_valid   in   1     in_digit/in_last valid
//  in_ready   out  1     block accepts a digit this cycle
//  in_digit   in   2     raw DNA digit (A=0,C=1,G=2,T=3)
//  in_last    in   1     accompanying digit is final digit of the word
//  out_valid  out  1     word_out/word_len valid, held until accepted
//  out_ready  in   1     downstream accepts the word
//  word_out   out  2*N   encoded word; digit i at bits [2i+1:2i], unused digits 0
//  word_len   out  7     index of last valid digit (digit count - 1)
//  overflow   out  1     1-cycle pulse: word closed at N digits without in_last
// BEHAVIOUR
//  Reset: state IDLE, in_ready=0 during rst then 1 in IDLE, out_valid=0, word_out=0, word_len=0,
//   overflow=0, digit counter cnt=0, ref=INIT_REF. Reset mid-word discards the partial word.
//  Encoding: enc = (ref + in_digit) mod 4 (2-bit wrap); ref <= enc after each accepted digit.
//  Accept = in_valid & in_ready; enc stored at digit slot cnt; cnt increments by 1.
//  States:
//   IDLE: in_ready=1, word register cleared; on accept -> FILL (cnt=1), or -> HOLD if in_last.
//   FILL: in_ready=1; on accept with in_last, or with cnt==N-1 -> HOLD.
//   HOLD: in_ready=0, out_valid=1, word_out/word_len stable; on out_ready -> IDLE, ref<=INIT_REF,
//         cnt<=0, word register cleared next cycle.
//  Latency: out_valid rises the cycle after the accept of the closing digit.
//  word_len = cnt-1 at closing, i.e. closing-digit index; single-digit word -> word_len=0.
//  Overflow: N-th digit accepted with in_last=0 -> word closes, overflow pulses with transition to HOLD;
//   the next digit starts a new word (ref reset to INIT_REF).
//  in_valid with in_ready=0 is ignored (no capture); upstream must hold data.
//  out_valid never drops without out_ready; no new input accepted in HOLD (no bubble-skipping).
//  Throughput: one digit/cycle in FILL; one dead cycle (HOLD handshake) per word minimum.
//  No combinational path from out_ready to in_ready.
// STRUCTURE
//  dna_pkg: typedef logic [1:0] dna_digit_t; enum {A,C,G,T}; typedef enum {IDLE,FILL,HOLD} enc_state_t;
//   localparam LEN_W=7.
//  Sub-module diff_digit: combinational mod-4 adder (ref, digit) -> enc; reused by a future decoder
//   (subtract mode). Top holds FSM, counter, ref register and word shift/index register.
// TESTING
//  1 rst mid-FILL after 5 digits -> out_valid=0, cnt=0; next word starts from INIT_REF.
//  2 digits 1,1,1,1 (last on 4th), INIT_REF=0 -> word_out[7:0]=8'b00_11_10_01 (0,3,2,1 LSB-first
//    is 1,2,3,0), word_len=3, out_valid 1 cycle after last accept.
//  3 single digit 3 with in_last -> word_out=3, word_len=0; out_ready held 0 for 10 cycles -> outputs
//    stable, in_ready=0 throughout.
//  4 128 digits of 2, no in_last -> overflow pulse, word_len=127, digits alternate 2,0,2,0...
//  5 back-to-back words with out_ready=1 -> second word encodes from INIT_REF, upper digits zero.
//  6 random in_valid/out_ready gaps vs. reference model -> every word matches, no digit lost/duplicated.

Source files
------------

// File: rtl/dna_pkg.sv
// ============================================================================
// Package : dna_pkg
// Brief   : Shared types and constants for DNA digit encode/decode blocks.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package dna_pkg;

    // Width of the word-length field (index of last digit, N <= 128)
    localparam int LEN_W = 7;

    // One DNA digit, two bits
    typedef logic [1:0] dna_digit_t;

    // Symbolic base values (A=0, C=1, G=2, T=3)
    typedef enum logic [1:0] {
        DNA_A = 2'd0,
        DNA_C = 2'd1,
        DNA_G = 2'd2,
        DNA_T = 2'd3
    } dna_base_t;

    // Encoder word-assembly states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        HOLD = 2'd2
    } enc_state_t;

    // Modulo-4 sum of two digits; the 2-bit result wraps naturally
    function automatic dna_digit_t mod4_add(input dna_digit_t a, input dna_digit_t b);
        return dna_digit_t'(a + b);
    endfunction

endpackage

`default_nettype wire

// File: rtl/diff_digit.sv
// ============================================================================
// Module : diff_digit
// Brief  : Combinational mod-4 differential digit stage. sub=0 encodes
//          (ref + digit), sub=1 decodes (digit - ref) for a matching decoder.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module diff_digit
    import dna_pkg::*;
(
    input  logic       sub,
    input  dna_digit_t ref_digit,
    input  dna_digit_t digit,
    output dna_digit_t enc
);

    // Mod-4 add or subtract, chosen by mode
    always_comb begin
        enc = mod4_add(ref_digit, digit);
        if (sub) begin
            enc = dna_digit_t'(digit - ref_digit);
        end
    end

endmodule

`default_nettype wire

// File: rtl/diff_word_encoder.sv
// ============================================================================
// Module : diff_word_encoder
// Brief  : Streaming differential DNA encoder. Each accepted digit is encoded
//          as a running mod-4 sum and packed into an N-digit word, which is
//          then offered downstream with its last-digit index via valid/ready.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module diff_word_encoder
    import dna_pkg::*;
#(
    parameter int         N        = 128,
    parameter dna_digit_t INIT_REF = 2'd0
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_digit,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*N-1:0]   word_out,
    output logic [LEN_W-1:0] word_len,
    output logic             overflow
);

    // Counter needs one extra bit so it can reach N itself
    localparam int CNT_W = LEN_W + 1;

    enc_state_t        state;
    logic [CNT_W-1:0]  cnt;
    dna_digit_t        ref_digit;
    dna_digit_t        enc;
    logic [2*N-1:0]    word_q;
    logic [LEN_W-1:0]  len_q;
    logic              overflow_q;
    logic              accept;
    logic              closing;

    // Ready depends only on state and reset, never on out_ready
    assign in_ready  = ~rst & (state != HOLD);
    assign out_valid = (state == HOLD);
    assign accept    = in_valid & in_ready;
    // Word closes on an explicit last digit or when the final slot fills
    assign closing   = in_last | (cnt == CNT_W'(N - 1));

    assign word_out  = word_q;
    assign word_len  = len_q;
    assign overflow  = overflow_q;

    diff_digit u_diff_digit (
        .sub       (1'b0),
        .ref_digit (ref_digit),
        .digit     (in_digit),
        .enc       (enc)
    );

    // FSM, digit counter and running reference digit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            ref_digit <= INIT_REF;
        end else begin
            case (state)
                IDLE, FILL: begin
                    if (accept) begin
                        cnt       <= cnt + 1'b1;
                        ref_digit <= enc;
                        state     <= closing ? HOLD : FILL;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        cnt       <= '0;
                        ref_digit <= INIT_REF;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cnt       <= '0;
                    ref_digit <= INIT_REF;
                end
            endcase
        end
    end

    // Word packing, length capture and overflow pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q     <= '0;
            len_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            // Overflow is high only in the first HOLD cycle of a forced close
            overflow_q <= accept & closing & ~in_last;
            if (accept) begin
                for (int i = 0; i < N; i++) begin
                    if (cnt == CNT_W'(i)) begin
                        word_q[2*i +: 2] <= enc;
                    end
                end
                if (closing) begin
                    len_q <= cnt[LEN_W-1:0];
                end
            end else if ((state == HOLD) && out_ready) begin
                // Clearing on handoff keeps unused upper digits zero next word
                word_q <= '0;
                len_q  <= '0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_diff_word_encoder.sv
// ============================================================================
// Module : tb_diff_word_encoder
// Brief  : Scoreboard bench for diff_word_encoder with a digit-stream model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_diff_word_encoder;

    localparam int N = 128;

    typedef struct {
        logic [2*N-1:0] word;
        logic [6:0]     len;
        bit             ovf;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [1:0]     in_digit;
    logic           in_last;
    logic           out_valid;
    logic           out_ready;
    logic [2*N-1:0] word_out;
    logic [6:0]     word_len;
    logic           overflow;

    int   checks   = 0;
    int   failures = 0;
    int   ready_mode = 1;   // 0: hold low, 1: hold high, 2: random
    exp_t exp_q[$];

    // Reference model state: current partial word as plain arithmetic
    int             m_ref = 0;
    int             m_cnt = 0;
    logic [2*N-1:0] m_word = '0;

    diff_word_encoder #(.N(N), .INIT_REF(2'd0)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_digit  (in_digit),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .word_out  (word_out),
        .word_len  (word_len),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic model_reset();
        m_ref  = 0;
        m_cnt  = 0;
        m_word = '0;
    endtask

    // Running sum mod 4; a word ends at in_last or after N digits
    task automatic model_digit(input int d, input bit last);
        exp_t e;
        m_ref = (m_ref + d) % 4;
        m_word[2*m_cnt +: 2] = 2'(m_ref);
        m_cnt++;
        if (last || m_cnt == N) begin
            e.word = m_word;
            e.len  = 7'(m_cnt - 1);
            e.ovf  = !last;
            exp_q.push_back(e);
            model_reset();
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the digit is accepted
    task automatic send_digit(input int d, input bit last, input int max_gap);
        bit ok;
        bit closes;
        int budget;
        in_valid = 1'b0;
        repeat ($urandom_range(0, max_gap)) begin
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        in_digit = 2'(d);
        in_last  = last;
        ok = 1'b0;
        budget = 0;
        while (!ok && budget < 5000) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk); #1;
            budget++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout actual=0 required=1");
        end else begin
            closes = last || (m_cnt == N - 1);
            model_digit(d, last);
            if (closes) check("out_valid_latency", 256'(out_valid), 256'(1));
        end
    endtask

    task automatic drain();
        int budget = 0;
        while (exp_q.size() != 0 && budget < 5000) begin
            @(posedge clk); #1;
            budget++;
        end
        check("drain_empty", 256'(exp_q.size()), 256'(0));
    endtask

    // Downstream ready generator
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                default: out_ready = ($urandom_range(0, 2) != 0);
            endcase
        end
    end

    // Monitor: compares each handed-off word against the scoreboard head
    bit prev_valid = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            if (out_valid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_word actual=%h required=none", word_out);
                end else begin
                    check("overflow_flag", 256'(overflow), 256'(exp_q[0].ovf));
                end
            end else if (overflow) begin
                check("overflow_stray", 256'(overflow), 256'(0));
            end
            if (out_valid && out_ready && exp_q.size() != 0) begin
                check("word_out", 256'(word_out), 256'(exp_q[0].word));
                check("word_len", 256'(word_len), 256'(exp_q[0].len));
                void'(exp_q.pop_front());
            end
            prev_valid = out_valid;
        end
    end

    initial begin
        int len;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_digit = 2'd0;
        in_last  = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_in_ready",  256'(in_ready),  256'(0));
        check("rst_out_valid", 256'(out_valid), 256'(0));
        check("rst_word_out",  256'(word_out),  256'(0));
        check("rst_word_len",  256'(word_len),  256'(0));
        check("rst_overflow",  256'(overflow),  256'(0));
        rst = 1'b0;
        @(negedge clk);
        check("idle_in_ready", 256'(in_ready), 256'(1));
        @(posedge clk); #1;

        // Reset in the middle of a word discards it
        for (int i = 0; i < 5; i++) send_digit(3, 1'b0, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 256'(out_valid), 256'(0));
        check("midrst_in_ready",  256'(in_ready),  256'(0));
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        send_digit(2, 1'b0, 0);
        send_digit(3, 1'b1, 0);   // expects digits 2,1
        drain();

        // 1,1,1,1 encodes to 1,2,3,0
        for (int i = 0; i < 4; i++) send_digit(1, i == 3, 0);
        @(negedge clk);
        check("seq1111_byte", 256'(word_out[7:0]), 256'(8'b00_11_10_01));
        drain();

        // Single digit held with no downstream ready
        ready_mode = 0;
        @(posedge clk); #1;
        send_digit(3, 1'b1, 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_valid",    256'(out_valid), 256'(1));
            check("hold_in_ready", 256'(in_ready),  256'(0));
            check("hold_word",     256'(word_out),  256'(3));
            check("hold_len",      256'(word_len),  256'(0));
        end
        ready_mode = 1;
        drain();

        // Full word of 2s without last: overflow, alternating 2,0
        for (int i = 0; i < N; i++) send_digit(2, 1'b0, 0);
        drain();

        // Back-to-back words with ready high
        for (int i = 0; i < 6; i++) send_digit(3, i == 5, 0);
        for (int i = 0; i < 2; i++) send_digit(1, i == 1, 0);
        drain();

        // Random digits, lengths, gaps and downstream stalls
        ready_mode = 2;
        for (int w = 0; w < 30; w++) begin
            len = ($urandom_range(0, 7) == 0) ? $urandom_range(N - 2, N + 20)
                                              : $urandom_range(1, 24);
            for (int i = 0; i < len; i++)
                send_digit($urandom_range(0, 3), i == len - 1, 2);
        end
        ready_mode = 1;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
